quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Receive-side counterpart of the quadrature encoder; turns the two-phase A/B signals back into step, direction and position.
- Synchronizes asynchronous A/B lines and decodes Gray-code transitions into +1/-1 steps.
- Keeps a signed position counter, flags illegal transitions, and feeds the motor/position-control logic.

Parameters:
COUNT_W, 16, width of signed position counter (two's complement)
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2)
FILTER_LEN, 4, consecutive stable samples required per line (used only with QDEC_FILTER_EN)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
a_in  input  1  phase A, asynchronous
b_in  input  1  phase B, asynchronous
clr  input  1  synchronous clear of pos and err
pos  output  COUNT_W  signed position count
step  output  1  one-cycle pulse per decoded legal transition
dir  output  1  direction of last step: 1 = clockwise (+1), 0 = counter-clockwise (-1)
err  output  1  sticky illegal-transition flag
valid  output  1  high once decoder is tracking

Behaviour:
- Reset (rst_n=0 at a clk edge): synchronizer flops 0, pos=0, step=0, dir=0, err=0, valid=0, FSM=FILL.
- Phase encoding is AB = {a,b}.
- Clockwise sequence: 00->10->11->01->00.
- Counter-clockwise sequence: 00->01->11->10->00.
- FSM FILL:
  - Counts SYNC_STAGES cycles (plus FILTER_LEN when the filter is enabled) so the pipeline holds real samples.
  - Then goes to PRIME.
  - No steps, no errors.
- FSM PRIME (1 cycle):
  - prev_ab <= synced AB; valid <= 1; goes to TRACK.
  - No step, even if the line level is not 00.
- FSM TRACK, each cycle, comparing synced AB against prev_ab:
  - Equal: nothing.
  - One-bit change matching the CW sequence: step=1, dir=1, pos+1.
  - One-bit change matching the CCW sequence: step=1, dir=0, pos-1.
  - Both bits changed: err<=1, no step, pos unchanged, dir unchanged.
  - prev_ab <= synced AB in all cases.
- Latency (no filter): input change stable before edge 1 -> synced at edge SYNC_STAGES -> step/pos update at edge SYNC_STAGES+1.
- step is high for exactly one cycle per transition; back-to-back transitions on consecutive cycles give consecutive pulses.
- dir holds its value between steps.
- pos wraps: max positive +1 -> most negative; most negative -1 -> max positive. No saturation, no flag.
- clr:
  - pos<=0 and err<=0. clr overrides a same-cycle pos update.
  - step/dir are still reported for a same-cycle transition.
  - An illegal transition in the same cycle as clr sets err (set wins).
  - clr has no effect on FSM state.
- rst_n low mid-operation: everything returns to its reset value at that edge and the decoder re-enters FILL; no step is emitted across reset.

Optional Feature:
QDEC_FILTER_EN
- Defined:
  - Each synced line passes through a glitch filter.
  - The filtered output changes only after FILTER_LEN consecutive identical samples that differ from the current filtered value.
  - Latency increases by FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - The filter counter resets to 0 and the filtered value to 0 on reset.
- Undefined: filter logic is absent; synced lines feed the decoder directly; FILTER_LEN is unused.

Decomposition:
- Package qdec_pkg:
  - FSM state enum (FILL, PRIME, TRACK).
  - Direction constants DIR_CW=1, DIR_CCW=0.
  - 2-bit phase constants for the four AB codes.
  - Transition-classification function (none/cw/ccw/illegal).
- Sub-module qdec_line_sync:
  - Per-line SYNC_STAGES synchronizer plus optional filter.
  - Instantiated twice, for A and B.

Test Plan:
- Reset, hold AB=11 for 10 cycles -> valid rises after FILL+PRIME; pos=0, step never asserted, err=0.
- Drive CW sequence 00,10,11,01,00 with 8 cycles per phase -> 4 step pulses, each SYNC_STAGES+1 edges after its change; dir=1; pos=4.
- Drive CCW sequence for 6 transitions starting from pos=4 -> pos=-2 (0xFFFE for COUNT_W=16); dir=0.
- From AB=00 jump to 11 -> err=1, no step, pos unchanged; then assert clr -> err=0, pos=0.
- Preload pos to 0x7FFF via 32767 CW steps, then one more CW step -> pos=0x8000; one CCW step -> pos=0x7FFF.
- With QDEC_FILTER_EN: 2-cycle glitch on a_in -> no step; a 5-cycle-stable change -> exactly one step, delayed by FILTER_LEN extra cycles.

Source files
------------

// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types, constants and transition classifier for the quadrature decoder (QDEC_FILTER_EN selects the glitch filter)
package qdec_pkg;
  typedef enum logic [1:0] {FILL = 2'd0, PRIME = 2'd1, TRACK = 2'd2} qdec_state_e;
  typedef enum logic [1:0] {TR_NONE, TR_CW, TR_CCW, TR_ILL} qdec_tr_e;
  localparam logic DIR_CW = 1'b1;
  localparam logic DIR_CCW = 1'b0;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
`ifdef QDEC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  // CW successor of {a,b} is {~b,a}; CCW successor is {b,~a}
  function automatic qdec_tr_e classify(logic [1:0] prev, logic [1:0] cur);
    return cur == prev ? TR_NONE :
           cur == {~prev[0], prev[1]} ? TR_CW :
           cur == {prev[0], ~prev[1]} ? TR_CCW : TR_ILL;
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: phase inputs, clear and decoded outputs of the quadrature decoder
interface quad_decoder_if #(parameter int COUNT_W = 16);
  logic a_in;
  logic b_in;
  logic clr;
  logic signed [COUNT_W-1:0] pos;
  logic step;
  logic dir;
  logic err;
  logic valid;
  modport master(output a_in, b_in, clr, input pos, step, dir, err, valid);
  modport slave(input a_in, b_in, clr, output pos, step, dir, err, valid);
endinterface

// File: rtl/qdec_line_sync.sv
// qdec_line_sync: per-line synchronizer with optional glitch filter (QDEC_FILTER_EN)
module qdec_line_sync #(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync;
  always_ff @(posedge clk) sync <= !rst_n ? '0 : {sync[SYNC_STAGES-2:0], d};
`ifdef QDEC_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] cnt;
  logic filt;
  // filt follows the line only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      filt <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt) cnt <= '0;
    else if (cnt == FW'(FILTER_LEN - 1)) begin
      cnt <= '0;
      filt <= sync[SYNC_STAGES-1];
    end else cnt <= cnt + FW'(1);
  assign q = filt;
`else
  assign q = sync[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: A/B quadrature decoder with signed position, step/dir pulses and sticky error (QDEC_FILTER_EN adds glitch filters)
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  quad_decoder_if.slave bus
);
  localparam int FILL_N = SYNC_STAGES + (FILTER_EN ? FILTER_LEN : 0);
  localparam int FW = $clog2(FILL_N + 1);
  logic a_s, b_s, tracking, moved;
  logic [1:0] ab, prev_ab;
  logic [FW-1:0] fill_cnt;
  qdec_state_e state;
  qdec_tr_e tr;
  qdec_line_sync #(.SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_a (.clk(clk), .rst_n(rst_n), .d(bus.a_in), .q(a_s));
  qdec_line_sync #(.SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_b (.clk(clk), .rst_n(rst_n), .d(bus.b_in), .q(b_s));
  assign ab = {a_s, b_s};
  assign tr = classify(prev_ab, ab);
  assign tracking = state == TRACK;
  assign moved = tracking && (tr == TR_CW || tr == TR_CCW);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= FILL;
      fill_cnt <= '0;
      prev_ab <= AB_00;
      bus.pos <= '0;
      bus.step <= 1'b0;
      bus.dir <= DIR_CCW;
      bus.err <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      prev_ab <= ab;
      if (state == FILL) fill_cnt <= fill_cnt + FW'(1);
      state <= state != FILL ? TRACK : fill_cnt == FW'(FILL_N - 1) ? PRIME : FILL;
      if (state == PRIME) bus.valid <= 1'b1;
      bus.step <= moved;
      if (moved) bus.dir <= tr == TR_CW ? DIR_CW : DIR_CCW;
      // clear beats a same-cycle count update, but an illegal transition beats clear for err
      bus.pos <= bus.clr ? '0 :
                 moved ? (tr == TR_CW ? bus.pos + COUNT_W'(1) : bus.pos - COUNT_W'(1)) : bus.pos;
      bus.err <= (tracking && tr == TR_ILL) || (bus.err && !bus.clr);
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized and directed checks of quad_decoder against a cycle-level Gray-position model
module tb_quad_decoder;
  localparam int CNT_W = 16;
  localparam int S = 2;
  localparam int L = 4;
`ifdef QDEC_FILTER_EN
  localparam int N = S + L;
`else
  localparam int N = S;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  quad_decoder_if #(.COUNT_W(CNT_W)) bus();
  quad_decoder #(.COUNT_W(CNT_W), .SYNC_STAGES(S), .FILTER_LEN(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  int dsteps = 0;
  logic [1:0] gcode [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] q [$];
  logic [1:0] prev, f, drv;
  int run [2];
  int e;
  logic [CNT_W-1:0] m_pos;
  logic m_step, m_dir, m_err, m_valid;

  task automatic check(string tag, logic [CNT_W-1:0] got, logic [CNT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gidx(logic [1:0] v);
    for (int i = 0; i < 4; i++) if (gcode[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    repeat (S) q.push_back(2'b00);
    e = 0; f = 2'b00; run[0] = 0; run[1] = 0; prev = 2'b00;
    m_pos = '0; m_step = 0; m_dir = 0; m_err = 0; m_valid = 0;
  endtask

  task automatic tick();
    logic [1:0] cur, seen, dec;
    logic c, r, ill;
    int d;
    cur = {bus.a_in, bus.b_in}; c = bus.clr; r = rst_n;
    @(posedge clk); #1;
    if (!r) model_reset();
    else begin
      seen = q.pop_front();
      q.push_back(cur);
      dec = seen;
`ifdef QDEC_FILTER_EN
      dec = f;
      for (int i = 0; i < 2; i++)
        if (seen[i] != f[i]) begin
          run[i]++;
          if (run[i] == L) begin f[i] = seen[i]; run[i] = 0; end
        end else run[i] = 0;
`endif
      e++; m_step = 0; ill = 0;
      if (e == N + 1) begin prev = dec; m_valid = 1; end
      else if (e > N + 1) begin
        d = (gidx(dec) - gidx(prev) + 4) % 4;
        if (d == 1) begin m_pos++; m_dir = 1; m_step = 1; end
        if (d == 3) begin m_pos--; m_dir = 0; m_step = 1; end
        if (d == 2) ill = 1;
        prev = dec;
      end
      if (c) m_pos = '0;
      m_err = ill | (m_err & !c);
    end
    dsteps += int'(bus.step);
    check("step", CNT_W'(bus.step), CNT_W'(m_step));
    check("pos", bus.pos, m_pos);
    check("dir", CNT_W'(bus.dir), CNT_W'(m_dir));
    check("err", CNT_W'(bus.err), CNT_W'(m_err));
    check("valid", CNT_W'(bus.valid), CNT_W'(m_valid));
  endtask

  task automatic drive(logic [1:0] v, int cycles);
    drv = v; bus.a_in = v[1]; bus.b_in = v[0];
    repeat (cycles) tick();
  endtask

  task automatic do_reset(logic [1:0] v);
    rst_n = 1'b0;
    drive(v, 2);
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] nxt(logic [1:0] v, bit cw);
    return gcode[(gidx(v) + (cw ? 1 : 3)) % 4];
  endfunction

  initial begin
    int ds, r;
    bus.clr = 1'b0;
    model_reset();
    do_reset(2'b11);
    drive(2'b11, 10);
    check("t1_valid", CNT_W'(bus.valid), 1);
    check("t1_pos", bus.pos, 0);
    check("t1_steps", CNT_W'(dsteps), 0);
    check("t1_err", CNT_W'(bus.err), 0);
    do_reset(2'b00);
    drive(2'b00, N + 4);
    ds = dsteps;
    foreach (gcode[i]) drive(gcode[(i + 1) % 4], 8 + L);
    check("cw_steps", CNT_W'(dsteps - ds), 4);
    check("cw_dir", CNT_W'(bus.dir), 1);
    check("cw_pos", bus.pos, 16'd4);
    for (int i = 0; i < 6; i++) drive(nxt(drv, 0), 8 + L);
    check("ccw_pos", bus.pos, 16'hFFFE);
    check("ccw_dir", CNT_W'(bus.dir), 0);
    drive(2'b10, 8 + L);
    drive(2'b00, 8 + L);
    ds = dsteps;
    drive(2'b11, 8 + L);
    check("ill_err", CNT_W'(bus.err), 1);
    check("ill_pos", bus.pos, 16'hFFFC);
    check("ill_steps", CNT_W'(dsteps - ds), 0);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0; tick();
    check("clr_err", CNT_W'(bus.err), 0);
    check("clr_pos", bus.pos, 0);
    for (int i = 0; i < 32767; i++) drive(nxt(drv, 1), 1 + L);
    drive(drv, S + L + 3);
    check("wrap_max", bus.pos, 16'h7FFF);
    drive(nxt(drv, 1), S + L + 3);
    check("wrap_neg", bus.pos, 16'h8000);
    drive(nxt(drv, 0), S + L + 3);
    check("wrap_back", bus.pos, 16'h7FFF);
`ifdef QDEC_FILTER_EN
    ds = dsteps;
    drive({~drv[1], drv[0]}, 2);
    drive({~drv[1], drv[0]}, S + L + 4);
    check("glitch_steps", CNT_W'(dsteps - ds), 0);
    drive({~drv[1], drv[0]}, S + L + 4);
    check("filt_steps", CNT_W'(dsteps - ds), 1);
`endif
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 75) drive(nxt(drv, 1'($urandom_range(1))), $urandom_range(1, 3 + L));
      else if (r < 85) drive(~drv, $urandom_range(1, 3));
      else if (r < 93) begin
        bus.clr = 1'b1;
        if (r < 89) drive(nxt(drv, 1), 1); else tick();
        bus.clr = 1'b0;
      end else if (r < 97) drive(drv, $urandom_range(1, 4));
      else do_reset(drv);
    end
    drive(drv, S + L + 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
